// File: rtl/cipher_result_checker.sv
// cipher_result_checker
// Waits a fixed settle time after each start pulse, captures the cipher
// core's ciphertext, compares it with a golden value and keeps saturating
// pass/fail tallies. A status LED stays dark until the first check, blinks
// slowly while every check has passed, and blinks fast once any check failed.
//
// Ports
//   sys_clk   : system clock (only clock)
//   sys_rst_n : synchronous active-low reset
//   start     : one-cycle pulse, new stimulus applied to the cipher core
//   result    : ciphertext, big-endian (bit 0 is the MSB)
//   busy      : high while a check is in progress
//   done      : one-cycle pulse when a comparison completes
//   match     : outcome of the last comparison, valid from done onward
//   pass_cnt  : saturating count of passed checks
//   fail_cnt  : saturating count of failed checks
//   overrun   : sticky, start arrived while a check was in progress
//   led_out   : status LED drive
module cipher_result_checker #(
    parameter logic [127:0] EXPECTED      = 128'h0,
    parameter int unsigned  SETTLE_CYCLES = 100,
    parameter int unsigned  BLINK_HALF    = 25_000_000
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         start,
    input  logic [0:127] result,
    output logic         busy,
    output logic         done,
    output logic         match,
    output logic [15:0]  pass_cnt,
    output logic [15:0]  fail_cnt,
    output logic         overrun,
    output logic         led_out
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned BLINK_W   = 32;
    localparam int unsigned SLOW_LAST = BLINK_HALF - 1;
    localparam int unsigned FAST_LAST = (BLINK_HALF / 8) - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SAMPLE  = 2'd2,
        COMPARE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BLINK_OFF  = 2'd0,
        BLINK_SLOW = 2'd1,
        BLINK_FAST = 2'd2
    } blink_t;

    state_t               state;
    logic [CNT_W-1:0]     settle_cnt;
    logic [0:127]         capture;

    blink_t               blink_mode;
    blink_t               mode_c;
    logic [BLINK_W-1:0]   blink_cnt;
    logic [BLINK_W-1:0]   blink_last_c;

    // Check sequencer: settle, capture, compare, tally.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            capture    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            match      <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            overrun    <= 1'b0;
        end else begin
            done <= 1'b0;

            // Any start outside IDLE (COMPARE included) is dropped but flagged.
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    capture <= result;
                    state   <= COMPARE;
                end
                COMPARE: begin
                    match <= (capture == EXPECTED);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (capture == EXPECTED) begin
                        if (pass_cnt != 16'hFFFF) begin
                            pass_cnt <= pass_cnt + 16'd1;
                        end
                    end else begin
                        if (fail_cnt != 16'hFFFF) begin
                            fail_cnt <= fail_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Blink mode follows the tallies; any failure wins over passes.
    always_comb begin
        mode_c       = BLINK_OFF;
        blink_last_c = BLINK_W'(SLOW_LAST);
        if (fail_cnt != 16'd0) begin
            mode_c       = BLINK_FAST;
            blink_last_c = BLINK_W'(FAST_LAST);
        end else if (pass_cnt != 16'd0) begin
            mode_c = BLINK_SLOW;
        end
    end

    // LED divider; the count restarts whenever the mode changes.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            blink_mode <= BLINK_OFF;
            blink_cnt  <= '0;
            led_out    <= 1'b0;
        end else if (mode_c != blink_mode) begin
            blink_mode <= mode_c;
            blink_cnt  <= '0;
            if (mode_c == BLINK_OFF) begin
                led_out <= 1'b0;
            end
        end else if (blink_mode == BLINK_OFF) begin
            blink_cnt <= '0;
            led_out   <= 1'b0;
        end else if (blink_cnt == blink_last_c) begin
            blink_cnt <= '0;
            led_out   <= ~led_out;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule

// File: doc/cipher_result_checker.md
CIPHER_RESULT_CHECKER -- requirements
Module: cipher_result_checker

Interface
REQ-001 The block SHALL have parameter EXPECTED, default 128'h0, meaning the 128-bit golden ciphertext; bit 0 of result compares with the MSB of EXPECTED.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 100, range 1..65535, meaning sys_clk cycles to wait after start before sampling result.
REQ-003 The block SHALL have parameter BLINK_HALF, default 25_000_000, minimum 8, meaning the LED half-period in sys_clk cycles.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the 50 MHz system clock, and the only clock.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse meaning new stimulus was applied to the cipher core.
REQ-007 The block SHALL have port result, input, [0:127]: ciphertext from the cipher core, big-endian, bit 0 MSB.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a check is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when a comparison completes.
REQ-010 The block SHALL have port match, output, 1 bit: outcome of the last comparison, valid from done onward.
REQ-011 The block SHALL have ports pass_cnt and fail_cnt, outputs, 16 bits each: saturating counts of passed and failed checks.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag meaning start arrived while busy.
REQ-013 The block SHALL have port led_out, output, 1 bit: status LED drive.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SETTLE, SAMPLE and COMPARE, with every transition taken on the sys_clk rising edge.
REQ-015 In IDLE with start=1, the FSM SHALL go to SETTLE and clear the 16-bit settle counter; in IDLE with start=0, it SHALL stay in IDLE.
REQ-016 In SETTLE, the settle counter SHALL increment each cycle, and the FSM SHALL go to SAMPLE on the cycle the counter equals SETTLE_CYCLES-1.
REQ-017 In SAMPLE, the block SHALL register result into a 128-bit capture register, then go to COMPARE.
REQ-018 In COMPARE, the block SHALL set match to (capture == EXPECTED), pulse done for exactly one cycle, increment pass_cnt or fail_cnt, and return to IDLE.
REQ-019 Latency SHALL be fixed: done is high in the cycle SETTLE_CYCLES+2 edges after the edge that sampled start=1.
REQ-020 busy SHALL be high in SETTLE, SAMPLE and COMPARE, and low in IDLE.
REQ-021 A start=1 in any state other than IDLE SHALL be ignored for sequencing and SHALL set overrun; overrun is cleared only by reset.
REQ-022 A start=1 in the same cycle as COMPARE SHALL be treated as an overrun; a new check begins only on a start sampled in IDLE.
REQ-023 pass_cnt and fail_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-024 Changes on result outside the SAMPLE cycle SHALL have no effect on match.
REQ-025 led_out SHALL be held 0 while pass_cnt and fail_cnt are both 0.
REQ-026 When fail_cnt is 0 and pass_cnt is at least 1, led_out SHALL toggle every BLINK_HALF cycles (slow blink).
REQ-027 When fail_cnt is at least 1, led_out SHALL toggle every BLINK_HALF/8 cycles, integer division (fast blink).
REQ-028 The blink counter SHALL restart from 0 whenever the blink mode changes, and at wrap.

Reset
REQ-029 While sys_rst_n=0 at a rising edge, the block SHALL set: FSM=IDLE, busy=0, done=0, match=0, pass_cnt=0, fail_cnt=0, overrun=0, led_out=0, capture=0, settle and blink counters=0.
REQ-030 Reset asserted mid-check SHALL abort the check with no done pulse and no counter update.
REQ-031 After reset release, the first start SHALL begin a full new check.

Verification
REQ-032 The bench SHALL cover this pass case: SETTLE_CYCLES=4, EXPECTED=0, result=0, single start pulse -> done high exactly 6 cycles after start, match=1, pass_cnt=1, fail_cnt=0, busy low next cycle.
REQ-033 The bench SHALL cover this fail case: result=128'h1, start -> match=0, fail_cnt=1; with BLINK_HALF=16, led_out toggles every 2 cycles.
REQ-034 The bench SHALL cover an overrun: a second start 2 cycles after the first -> overrun=1, only one done pulse, pass_cnt+fail_cnt=1.
REQ-035 The bench SHALL cover a late result change: result=0 until SAMPLE, then 128'hFF after it -> match=1; result=128'hFF during SAMPLE -> match=0.
REQ-036 The bench SHALL cover reset mid-check: sys_rst_n=0 while in SETTLE -> no done pulse, all outputs 0, and the next start completes normally.
REQ-037 The bench SHALL cover saturation: pass_cnt preloaded by forcing to 16'hFFFF, then a pass -> pass_cnt stays 16'hFFFF; with BLINK_HALF=16 and passes only, led_out toggles every 16 cycles.
